hex_cmd_parser: RTL

- Byte-level command parser that sits directly downstream of the UART receiver (12 MHz clock, 115200 baud, 8N1).
- Recognises frames of the form: command character, then NDIGITS ASCII hex digits. Example: "S0F7" yields value 0x0F7.
- Presents the decoded value to the application logic with a one-cycle strobe.
- Queues a one-byte ACK/NAK response to the UART transmitter through a start/busy handshake.

---
 rtl/hex_cmd_pkg.sv | 20 ++
 rtl/hex_nibble_decode.sv | 31 +++
 rtl/hex_cmd_parser.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/hex_cmd_pkg.sv
// rtl/hex_cmd_pkg.sv - shared types and ASCII constants for hex command parsers
package hex_cmd_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIGITS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_9  = 8'h39;
    localparam logic [7:0] ASCII_UA = 8'h41;
    localparam logic [7:0] ASCII_UF = 8'h46;
    localparam logic [7:0] ASCII_LA = 8'h61;
    localparam logic [7:0] ASCII_LF = 8'h66;

    localparam logic [7:0] DEFAULT_ACK = 8'h4B;
    localparam logic [7:0] DEFAULT_NAK = 8'h3F;

endpackage

// File: rtl/hex_nibble_decode.sv
// rtl/hex_nibble_decode.sv - combinational ASCII hex digit to nibble decoder
//   i_byte      in  8  ASCII character
//   o_nibble    out 4  decoded value (0 when not a hex digit)
//   o_is_hex    out 1  high for '0'-'9', 'A'-'F', 'a'-'f'
module hex_nibble_decode
    import hex_cmd_pkg::*;
(
    input  logic [7:0] i_byte,
    output logic [3:0] o_nibble,
    output logic       o_is_hex
);

    logic [7:0] w_off;

    always_comb begin
        w_off    = 8'h00;
        o_is_hex = 1'b0;
        if (i_byte >= ASCII_0 && i_byte <= ASCII_9) begin
            w_off    = i_byte - ASCII_0;
            o_is_hex = 1'b1;
        end else if (i_byte >= ASCII_UA && i_byte <= ASCII_UF) begin
            w_off    = i_byte - ASCII_UA + 8'd10;
            o_is_hex = 1'b1;
        end else if (i_byte >= ASCII_LA && i_byte <= ASCII_LF) begin
            w_off    = i_byte - ASCII_LA + 8'd10;
            o_is_hex = 1'b1;
        end
        o_nibble = w_off[3:0];
    end

endmodule

// File: rtl/hex_cmd_parser.sv
// rtl/hex_cmd_parser.sv - UART byte stream parser for "<cmd><hex digits>" frames with ACK/NAK reply
//   Optional feature macro: CMD_TIMEOUT_EN (inter-character timeout inside a frame)
//   CLK          in  1          system clock
//   RST          in  1          asynchronous active-high reset
//   RX_DATA      in  8          received byte
//   RX_VALID     in  1          RX_DATA strobe
//   VALUE        out 4*NDIGITS  last decoded value
//   VALUE_VALID  out 1          pulse when VALUE updates
//   ERR          out 1          pulse on a bad or timed-out frame
//   TX_DATA      out 8          response byte
//   TX_START     out 1          transmit request pulse
//   TX_BUSY      in  1          transmitter busy
module hex_cmd_parser
    import hex_cmd_pkg::*;
#(
`ifdef CMD_TIMEOUT_EN
    parameter int         TIMEOUT_CYCLES = 12000,
`endif
    parameter logic [7:0] CMD_CHAR = 8'h53,
    parameter int         NDIGITS  = 3,
    parameter logic [7:0] ACK_CHAR = DEFAULT_ACK,
    parameter logic [7:0] NAK_CHAR = DEFAULT_NAK
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [7:0]           RX_DATA,
    input  logic                 RX_VALID,
    output logic [4*NDIGITS-1:0] VALUE,
    output logic                 VALUE_VALID,
    output logic                 ERR,
    output logic [7:0]           TX_DATA,
    output logic                 TX_START,
    input  logic                 TX_BUSY
);

    localparam int VW = 4 * NDIGITS;
    localparam int CW = $clog2(NDIGITS + 1);

    state_t          r_state, w_state_nxt;
    logic [VW-1:0]   r_shift, w_shift_nxt;
    logic [VW-1:0]   r_value, w_value_nxt;
    logic [CW-1:0]   r_count, w_count_nxt;
    logic [7:0]      r_resp, w_resp_nxt;
    logic [7:0]      r_tx_data, w_tx_data_nxt;
    logic            r_vv, w_vv_nxt;
    logic            r_err, w_err_nxt;
    logic            r_tx_start, w_tx_start_nxt;

    logic [3:0]      w_nibble;
    logic            w_is_hex;
    logic [VW+3:0]   w_ext;
    logic [VW-1:0]   w_shifted;
    logic            w_timeout;

    hex_nibble_decode u_decode (
        .i_byte   (RX_DATA),
        .o_nibble (w_nibble),
        .o_is_hex (w_is_hex)
    );

    // Append the new nibble at the LSB end; the oldest digit falls off the top.
    assign w_ext     = {r_shift, w_nibble};
    assign w_shifted = w_ext[VW-1:0];

`ifdef CMD_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    logic [TW-1:0] r_tmo, w_tmo_nxt;

    // Counts idle cycles inside DIGITS; any received byte restarts it, so a
    // byte landing on the terminal count wins over the timeout.
    assign w_timeout = (r_state == DIGITS) && !RX_VALID &&
                       (r_tmo == TW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        w_tmo_nxt = '0;
        if (r_state == DIGITS && !RX_VALID && !w_timeout)
            w_tmo_nxt = r_tmo + TW'(1);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) r_tmo <= '0;
        else     r_tmo <= w_tmo_nxt;
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_state_nxt    = r_state;
        w_shift_nxt    = r_shift;
        w_count_nxt    = r_count;
        w_value_nxt    = r_value;
        w_resp_nxt     = r_resp;
        w_tx_data_nxt  = r_tx_data;
        w_vv_nxt       = 1'b0;
        w_err_nxt      = 1'b0;
        w_tx_start_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                if (RX_VALID && RX_DATA == CMD_CHAR) begin
                    w_shift_nxt = '0;
                    w_count_nxt = '0;
                    w_state_nxt = DIGITS;
                end
            end
            DIGITS: begin
                if (RX_VALID) begin
                    if (RX_DATA == CMD_CHAR) begin
                        w_shift_nxt = '0;
                        w_count_nxt = '0;
                    end else if (w_is_hex) begin
                        if (r_count == CW'(NDIGITS - 1)) begin
                            w_value_nxt = w_shifted;
                            w_vv_nxt    = 1'b1;
                            w_resp_nxt  = ACK_CHAR;
                            w_shift_nxt = '0;
                            w_count_nxt = '0;
                            w_state_nxt = RESP;
                        end else begin
                            w_shift_nxt = w_shifted;
                            w_count_nxt = r_count + CW'(1);
                        end
                    end else begin
                        w_err_nxt   = 1'b1;
                        w_resp_nxt  = NAK_CHAR;
                        w_state_nxt = RESP;
                    end
                end else if (w_timeout) begin
                    w_err_nxt   = 1'b1;
                    w_resp_nxt  = NAK_CHAR;
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                // Bytes arriving here are dropped, including CMD_CHAR.
                if (!TX_BUSY) begin
                    w_tx_start_nxt = 1'b1;
                    w_tx_data_nxt  = r_resp;
                    w_state_nxt    = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state    <= IDLE;
            r_shift    <= '0;
            r_value    <= '0;
            r_count    <= '0;
            r_resp     <= 8'h00;
            r_tx_data  <= 8'h00;
            r_vv       <= 1'b0;
            r_err      <= 1'b0;
            r_tx_start <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_shift    <= w_shift_nxt;
            r_value    <= w_value_nxt;
            r_count    <= w_count_nxt;
            r_resp     <= w_resp_nxt;
            r_tx_data  <= w_tx_data_nxt;
            r_vv       <= w_vv_nxt;
            r_err      <= w_err_nxt;
            r_tx_start <= w_tx_start_nxt;
        end
    end

    assign VALUE       = r_value;
    assign VALUE_VALID = r_vv;
    assign ERR         = r_err;
    assign TX_DATA     = r_tx_data;
    assign TX_START    = r_tx_start;

endmodule
